// File: rtl/spectrum_ram_reader.sv
// spectrum_ram_reader: scans a bin window of the FFT-magnitude RAM once per
// start pulse. It finds the two largest bins and counts the bins at or
// above thr, then publishes the results with a one-cycle done pulse.
// Ports: clk, rst (sync, active-high), start, thr | rd_addr -> RAM,
//   rd_data <- RAM (RD_LAT clocks later) | busy, done, peak_addr/mag,
//   peak2_addr/mag, bins_above, sum_mag.
// Option: define SPEC_SUM_EN to build the magnitude-sum accumulator.
//   Without it, sum_mag is tied to 0.
module spectrum_ram_reader #(
  parameter int ADDR_W    = 8,
  parameter int DATA_W    = 16,
  parameter int BIN_START = 1,
  parameter int BIN_END   = 127,
  parameter int RD_LAT    = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [DATA_W-1:0]        thr,
  output logic [ADDR_W-1:0]        rd_addr,
  input  logic [DATA_W-1:0]        rd_data,
  output logic                     busy,
  output logic                     done,
  output logic [ADDR_W-1:0]        peak_addr,
  output logic [DATA_W-1:0]        peak_mag,
  output logic [ADDR_W-1:0]        peak2_addr,
  output logic [DATA_W-1:0]        peak2_mag,
  output logic [ADDR_W:0]          bins_above,
  output logic [DATA_W+ADDR_W-1:0] sum_mag
);

  localparam logic [ADDR_W-1:0] A_START = ADDR_W'(BIN_START);
  localparam logic [ADDR_W-1:0] A_END   = ADDR_W'(BIN_END);
  localparam logic [1:0]        D_LAST  = 2'(RD_LAT - 1);

  typedef enum logic [1:0] {
    IDLE,
    READ,
    DRAIN,
    DONE
  } state_t;

  state_t              state;
  logic [1:0]          dcnt;
  logic [DATA_W-1:0]   thr_q;
  logic [DATA_W-1:0]   max_m, max2_m;
  logic [ADDR_W-1:0]   max_a, max2_a;
  logic [ADDR_W:0]     cnt;

  // Valid/address tag travels alongside the RAM read pipeline.
  logic [RD_LAT-1:0]   tv;
  logic [ADDR_W-1:0]   ta [RD_LAT];

  logic                sv;
  logic [ADDR_W-1:0]   sa;
  logic [DATA_W-1:0]   n_max_m, n_max2_m;
  logic [ADDR_W-1:0]   n_max_a, n_max2_a;
  logic [ADDR_W:0]     n_cnt;
  logic                last;

  assign sv   = tv[RD_LAT-1];
  assign sa   = ta[RD_LAT-1];
  assign last = (state == DRAIN) && (dcnt == D_LAST);

  // Working values including the sample arriving this cycle, so the
  // final sample can be folded into the results on the DONE entry edge.
  always_comb begin
    n_max_m  = max_m;
    n_max_a  = max_a;
    n_max2_m = max2_m;
    n_max2_a = max2_a;
    n_cnt    = cnt;
    if (sv) begin
      if (rd_data > max_m) begin
        n_max2_m = max_m;
        n_max2_a = max_a;
        n_max_m  = rd_data;
        n_max_a  = sa;
      end else if (rd_data > max2_m) begin
        n_max2_m = rd_data;
        n_max2_a = sa;
      end
      if (rd_data >= thr_q)
        n_cnt = cnt + (ADDR_W+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      dcnt       <= '0;
      thr_q      <= '0;
      max_m      <= '0;
      max_a      <= '0;
      max2_m     <= '0;
      max2_a     <= '0;
      cnt        <= '0;
      tv         <= '0;
      for (int i = 0; i < RD_LAT; i++)
        ta[i] <= '0;
      rd_addr    <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      peak_addr  <= '0;
      peak_mag   <= '0;
      peak2_addr <= '0;
      peak2_mag  <= '0;
      bins_above <= '0;
    end else begin
      tv[0] <= (state == READ);
      ta[0] <= rd_addr;
      for (int i = 1; i < RD_LAT; i++) begin
        tv[i] <= tv[i-1];
        ta[i] <= ta[i-1];
      end
      max_m  <= n_max_m;
      max_a  <= n_max_a;
      max2_m <= n_max2_m;
      max2_a <= n_max2_a;
      cnt    <= n_cnt;
      done   <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            state   <= READ;
            busy    <= 1'b1;
            rd_addr <= A_START;
            thr_q   <= thr;
            max_m   <= '0;
            max_a   <= A_START;
            max2_m  <= '0;
            max2_a  <= A_START;
            cnt     <= '0;
          end
        end
        READ: begin
          if (rd_addr == A_END) begin
            state <= DRAIN;
            dcnt  <= '0;
          end else begin
            rd_addr <= rd_addr + ADDR_W'(1);
          end
        end
        DRAIN: begin
          if (dcnt == D_LAST) begin
            state      <= DONE;
            done       <= 1'b1;
            peak_addr  <= n_max_a;
            peak_mag   <= n_max_m;
            peak2_addr <= n_max2_a;
            peak2_mag  <= n_max2_m;
            bins_above <= n_cnt;
          end else begin
            dcnt <= dcnt + 2'd1;
          end
        end
        DONE: begin
          state   <= IDLE;
          busy    <= 1'b0;
          rd_addr <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SPEC_SUM_EN
  logic [DATA_W+ADDR_W-1:0] acc, n_acc;

  assign n_acc = sv ? acc + (DATA_W+ADDR_W)'(rd_data) : acc;

  always_ff @(posedge clk) begin
    if (rst) begin
      acc     <= '0;
      sum_mag <= '0;
    end else begin
      if (state == IDLE && start)
        acc <= '0;
      else
        acc <= n_acc;
      if (last)
        sum_mag <= n_acc;
    end
  end
`else
  assign sum_mag = '0;
`endif

endmodule

// File: tb/tb_spectrum_ram_reader.sv
// Bench for spectrum_ram_reader: two instances (RD_LAT=1 and RD_LAT=2)
// share one RAM image and are checked against a scan-level model.
module tb_spectrum_ram_reader;

  localparam int BS = 1;
  localparam int BE = 127;
  localparam int N  = BE - BS + 1;

  typedef struct packed {
    logic [7:0]  pa;
    logic [15:0] pm;
    logic [7:0]  p2a;
    logic [15:0] p2m;
    logic [8:0]  ba;
    logic [23:0] sm;
  } res_t;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] thr;
  logic [7:0]  ra  [2];
  logic [15:0] rdd [2];
  logic        bsy [2];
  logic        dn  [2];
  logic [7:0]  pa  [2];
  logic [15:0] pm  [2];
  logic [7:0]  p2a [2];
  logic [15:0] p2m [2];
  logic [8:0]  ba  [2];
  logic [23:0] sm  [2];

  logic [15:0] mem [256];
  logic [15:0] q1, q2a, q2b;

  int checks = 0;
  int fails  = 0;

  spectrum_ram_reader #(.RD_LAT(1)) u1 (
    .clk(clk), .rst(rst), .start(start), .thr(thr),
    .rd_addr(ra[0]), .rd_data(rdd[0]), .busy(bsy[0]), .done(dn[0]),
    .peak_addr(pa[0]), .peak_mag(pm[0]),
    .peak2_addr(p2a[0]), .peak2_mag(p2m[0]),
    .bins_above(ba[0]), .sum_mag(sm[0]));

  spectrum_ram_reader #(.RD_LAT(2)) u2 (
    .clk(clk), .rst(rst), .start(start), .thr(thr),
    .rd_addr(ra[1]), .rd_data(rdd[1]), .busy(bsy[1]), .done(dn[1]),
    .peak_addr(pa[1]), .peak_mag(pm[1]),
    .peak2_addr(p2a[1]), .peak2_mag(p2m[1]),
    .bins_above(ba[1]), .sum_mag(sm[1]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM models: 1-cycle and 2-cycle read latency.
  always @(posedge clk) begin
    q1  <= mem[ra[0]];
    q2a <= mem[ra[1]];
    q2b <= q2a;
  end
  assign rdd[0] = q1;
  assign rdd[1] = q2b;

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] want);
    checks++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s got=%h want=%h", nm, got, want);
    end
  endtask

  // Top-two selection over the whole window: largest value at its
  // lowest bin, then the largest of the remaining bins at its lowest bin.
  // A zero runner-up keeps the cleared default bin.
  function automatic res_t model(input logic [15:0] t);
    res_t r;
    int bv, sv;
    r  = '0;
    bv = -1;
    sv = -1;
    for (int b = BS; b <= BE; b++)
      if (int'(mem[b]) > bv) begin
        bv   = int'(mem[b]);
        r.pa = 8'(b);
      end
    for (int b = BS; b <= BE; b++)
      if (8'(b) != r.pa && int'(mem[b]) > sv) begin
        sv    = int'(mem[b]);
        r.p2a = 8'(b);
      end
    r.pm  = 16'(bv);
    r.p2m = 16'(sv);
    if (sv == 0) r.p2a = 8'(BS);
    for (int b = BS; b <= BE; b++) begin
      if (mem[b] >= t) r.ba = r.ba + 9'd1;
`ifdef SPEC_SUM_EN
      r.sm = r.sm + 24'(mem[b]);
`endif
    end
    return r;
  endfunction

  int   lat [2] = '{1, 2};
  int   cyc = 0;
  bit   arm = 0;
  bit   act [2];
  int   bfrom [2];
  int   dcyc [2];
  res_t pend [2];
  res_t pub  [2];
  bit   eb [2];
  bit   ed [2];
  logic [7:0] era [2];

  // Cycle-level expectations derived from the scan timeline.
  always @(posedge clk) begin
    cyc++;
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        arm    = 1;
        act[d] = 0;
        pub[d] = '0;
      end else begin
        if (!eb[d] && start) begin
          act[d]   = 1;
          bfrom[d] = cyc;
          dcyc[d]  = cyc + N + lat[d];
          pend[d]  = model(thr);
        end
        if (act[d] && cyc == dcyc[d]) pub[d] = pend[d];
        if (act[d] && cyc > dcyc[d]) act[d] = 0;
      end
      eb[d] = act[d] && cyc >= bfrom[d] && cyc <= dcyc[d];
      ed[d] = act[d] && cyc == dcyc[d];
      if (!eb[d]) era[d] = 8'd0;
      else if (cyc - bfrom[d] < N) era[d] = 8'(BS + cyc - bfrom[d]);
      else era[d] = 8'(BE);
    end
  end

  always @(negedge clk) begin
    if (arm) begin
      for (int d = 0; d < 2; d++) begin
        chk($sformatf("busy%0d", d), 32'(bsy[d]), 32'(eb[d]));
        chk($sformatf("done%0d", d), 32'(dn[d]), 32'(ed[d]));
        chk($sformatf("rd_addr%0d", d), 32'(ra[d]), 32'(era[d]));
        chk($sformatf("peak_addr%0d", d), 32'(pa[d]), 32'(pub[d].pa));
        chk($sformatf("peak_mag%0d", d), 32'(pm[d]), 32'(pub[d].pm));
        chk($sformatf("peak2_addr%0d", d), 32'(p2a[d]), 32'(pub[d].p2a));
        chk($sformatf("peak2_mag%0d", d), 32'(p2m[d]), 32'(pub[d].p2m));
        chk($sformatf("bins_above%0d", d), 32'(ba[d]), 32'(pub[d].ba));
        chk($sformatf("sum_mag%0d", d), 32'(sm[d]), 32'(pub[d].sm));
      end
    end
  end

  task automatic fill(input logic [15:0] v);
    for (int b = 0; b < 256; b++) mem[b] = v;
  endtask

  task automatic scan(input logic [15:0] t, input int extra_at,
                      input int rst_at, output int nd,
                      output int dk0, output int dk1);
    @(negedge clk);
    thr   = t;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    nd  = 0;
    dk0 = -1;
    dk1 = -1;
    for (int k = 1; k <= 200; k++) begin
      if (dn[0] === 1'b1) begin
        nd++;
        if (dk0 < 0) dk0 = k;
      end
      if (dn[1] === 1'b1 && dk1 < 0) dk1 = k;
      if (rst_at > 0 && k == rst_at + 1) begin
        chk("rst_peak_mag", 32'(pm[0]), 32'd0);
        chk("rst_bins_above", 32'(ba[0]), 32'd0);
        chk("rst_busy", 32'(bsy[0]), 32'd0);
      end
      if (extra_at > 0 && k == 130)
        chk("busy_at_130", 32'(bsy[0]), 32'd0);
      start = (k == extra_at);
      rst   = (k == rst_at);
      @(negedge clk);
    end
    start = 1'b0;
    rst   = 1'b0;
  endtask

  int nd, dk0, dk1;

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    thr   = '0;
    fill(16'h0000);
    repeat (3) @(negedge clk);
    chk("reset_busy", 32'(bsy[0]), 32'd0);
    chk("reset_peak_addr", 32'(pa[0]), 32'd0);
    chk("reset_rd_addr", 32'(ra[0]), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Flat RAM
    fill(16'h0010);
    scan(16'h0010, 0, 0, nd, dk0, dk1);
    chk("flat_done_cyc_lat1", 32'(dk0), 32'd129);
    chk("flat_done_cyc_lat2", 32'(dk1), 32'd130);
    chk("flat_peak_addr", 32'(pa[0]), 32'd1);
    chk("flat_peak2_addr", 32'(p2a[0]), 32'd2);
    chk("flat_bins_above", 32'(ba[0]), 32'd127);
    chk("flat_lat2_peak_addr", 32'(pa[1]), 32'd1);
    chk("flat_lat2_peak2_addr", 32'(p2a[1]), 32'd2);
`ifdef SPEC_SUM_EN
    chk("flat_sum", 32'(sm[0]), 32'h7F0);
`endif

    // Two distinct peaks
    fill(16'h0100);
    mem[40] = 16'h3000;
    mem[10] = 16'h1000;
    scan(16'h0800, 0, 0, nd, dk0, dk1);
    chk("pk_peak_addr", 32'(pa[0]), 32'd40);
    chk("pk_peak_mag", 32'(pm[0]), 32'h3000);
    chk("pk_peak2_addr", 32'(p2a[0]), 32'd10);
    chk("pk_peak2_mag", 32'(p2m[0]), 32'h1000);
    chk("pk_bins_above", 32'(ba[0]), 32'd2);
`ifdef SPEC_SUM_EN
    chk("pk_sum", 32'(sm[0]), 32'hBD00);
`endif

    // Equal peaks; bins outside the window are large and must be skipped
    fill(16'h0100);
    mem[0]   = 16'hFFFF;
    mem[128] = 16'hFFFF;
    mem[20]  = 16'h2000;
    mem[90]  = 16'h2000;
    scan(16'h2000, 0, 0, nd, dk0, dk1);
    chk("tie_peak_addr", 32'(pa[0]), 32'd20);
    chk("tie_peak2_addr", 32'(p2a[0]), 32'd90);
    chk("tie_peak2_mag", 32'(p2m[0]), 32'h2000);
    chk("tie_bins_above", 32'(ba[0]), 32'd2);

    // Second start mid-scan is ignored
    scan(16'h2000, 50, 0, nd, dk0, dk1);
    chk("dup_start_ndone", 32'(nd), 32'd1);
    chk("dup_start_done_cyc", 32'(dk0), 32'd129);

    // Reset mid-scan aborts with no done
    for (int b = 0; b < 256; b++) mem[b] = 16'(b << 8);
    scan(16'h4000, 0, 60, nd, dk0, dk1);
    chk("abort_ndone", 32'(nd), 32'd0);

    // Fresh scan after the abort
    scan(16'h4000, 0, 0, nd, dk0, dk1);
    chk("ramp_peak_addr", 32'(pa[0]), 32'd127);
    chk("ramp_peak2_addr", 32'(p2a[0]), 32'd126);
    chk("ramp_peak_mag", 32'(pm[0]), 32'h7F00);
    chk("ramp_bins_above", 32'(ba[0]), 32'd64);

    // Window edge bins, threshold at full scale
    fill(16'h0005);
    mem[1]   = 16'hFFFE;
    mem[127] = 16'hFFFF;
    scan(16'hFFFF, 0, 0, nd, dk0, dk1);
    chk("edge_peak_addr", 32'(pa[0]), 32'd127);
    chk("edge_peak2_addr", 32'(p2a[0]), 32'd1);
    chk("edge_bins_above", 32'(ba[0]), 32'd1);
    chk("edge_lat2_peak_addr", 32'(pa[1]), 32'd127);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
